// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side bus bundle for the simulink2ppc snapshot register.
// Bit 0 is the MSB of every OPB vector.
interface opb_register_simulink2ppc_snap_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a 32-bit fabric status word for the PowerPC to read.
// Optional macro SNAP_TIMESTAMP_EN adds a cycle counter captured into TSTAMP (0x8).
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01060600,
    parameter logic [31:0] C_HIGHADDR   = 32'h010606FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                                   OPB_Clk,
    input  logic                                   OPB_Rst_n,
    opb_register_simulink2ppc_snap_if.slave        opb,
    input  logic [31:0]                            user_data_in,
    input  logic                                   user_valid
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam int unused_familyLen = $bits(C_FAMILY);

    state_t                  state_q, state_d;
    logic [C_OPB_DWIDTH-1:0] snapshot_q, snapshot_d;
    logic                    newFlag_q, newFlag_d;
    logic                    overrun_q, overrun_d;
    logic                    freeze_q, freeze_d;
    logic [0:C_OPB_DWIDTH-1] rdData_q, rdData_d;

    // Side effects of the beat are decided at select time and applied in ACK.
    logic dataRd_q, dataRd_d;
    logic wrFreeze_q, wrFreeze_d;
    logic freezeVal_q, freezeVal_d;
    logic clrOvr_q, clrOvr_d;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [2:0]              offset;
    logic                    hit;
    logic                    capture;
    logic                    statWr;
    logic [31:0]             statWord;
    logic [31:0]             tstampWord;
    logic [C_OPB_DWIDTH-1:0] rdMux;
    logic                    unused_ok;

    assign addr     = opb.OPB_ABus;
    assign offset   = opb.OPB_ABus[27:29];
    assign hit      = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign capture  = user_valid && !freeze_q;
    assign statWr   = hit && !opb.OPB_RNW && (offset == 3'd1);
    assign statWord = {newFlag_q, overrun_q, 29'b0, freeze_q};

    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[1:2], opb.OPB_DBus[0],
                         opb.OPB_DBus[2:30]};

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] cycleCnt_q;
    logic [31:0] tstamp_q;

    // Counter value seen on the capture edge is stored, so a wrap-cycle capture keeps all ones.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cycleCnt_q <= '0;
            tstamp_q   <= '0;
        end else begin
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (capture) begin
                tstamp_q <= cycleCnt_q;
            end
        end
    end

    assign tstampWord = tstamp_q;
`else
    assign tstampWord = '0;
`endif

    always_comb begin
        rdMux = '0;
        if (opb.OPB_RNW) begin
            case (offset)
                3'd0:    rdMux = snapshot_q;
                3'd1:    rdMux = statWord;
                3'd2:    rdMux = tstampWord;
                default: rdMux = '0;
            endcase
        end
    end

    // Capture is evaluated last so it overrides a same-cycle read-clear or W1C.
    always_comb begin
        state_d     = state_q;
        rdData_d    = '0;
        snapshot_d  = snapshot_q;
        newFlag_d   = newFlag_q;
        overrun_d   = overrun_q;
        freeze_d    = freeze_q;
        dataRd_d    = dataRd_q;
        wrFreeze_d  = wrFreeze_q;
        freezeVal_d = freezeVal_q;
        clrOvr_d    = clrOvr_q;

        case (state_q)
            IDLE: begin
                dataRd_d    = hit && opb.OPB_RNW && (offset == 3'd0);
                wrFreeze_d  = statWr && opb.OPB_BE[3];
                freezeVal_d = opb.OPB_DBus[31];
                clrOvr_d    = statWr && opb.OPB_BE[0] && opb.OPB_DBus[1];
                if (hit) begin
                    state_d  = ACK;
                    rdData_d = rdMux;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (dataRd_q) begin
                    newFlag_d = 1'b0;
                end
                if (clrOvr_q) begin
                    overrun_d = 1'b0;
                end
                if (wrFreeze_q) begin
                    freeze_d = freezeVal_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            snapshot_d = user_data_in;
            newFlag_d  = 1'b1;
            if (newFlag_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q     <= IDLE;
            rdData_q    <= '0;
            snapshot_q  <= '0;
            newFlag_q   <= 1'b0;
            overrun_q   <= 1'b0;
            freeze_q    <= 1'b0;
            dataRd_q    <= 1'b0;
            wrFreeze_q  <= 1'b0;
            freezeVal_q <= 1'b0;
            clrOvr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdData_q    <= rdData_d;
            snapshot_q  <= snapshot_d;
            newFlag_q   <= newFlag_d;
            overrun_q   <= overrun_d;
            freeze_q    <= freeze_d;
            dataRd_q    <= dataRd_d;
            wrFreeze_q  <= wrFreeze_d;
            freezeVal_q <= freezeVal_d;
            clrOvr_q    <= clrOvr_d;
        end
    end

    assign opb.Sl_DBus    = rdData_q;
    assign opb.Sl_xferAck = (state_q == ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench for the simulink2ppc snapshot register: OPB reads/writes,
// capture, overrun, freeze, collision, window boundaries and reset mid-read.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01060600;

    logic        clk;
    logic        rstN;
    logic [31:0] userData;
    logic        userValid;
    int          vectors;
    int          miscompares;

    opb_register_simulink2ppc_snap_if bus ();

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rstN),
        .opb          (bus),
        .user_data_in (userData),
        .user_valid   (userValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One-cycle capture strobe, sampled on the posedge between two negedges.
    task automatic applyStimulus(input logic [31:0] data);
        @(negedge clk);
        userData  = data;
        userValid = 1'b1;
        @(negedge clk);
        userValid = 1'b0;
    endtask

    task automatic busIdle();
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = '0;
        bus.OPB_DBus   = '0;
        bus.OPB_BE     = 4'h0;
    endtask

    task automatic opbRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        #1;
        checkOutput({tag, " preack"}, {31'b0, bus.Sl_xferAck}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " ack"}, {31'b0, bus.Sl_xferAck}, 32'd1);
        checkOutput(tag, bus.Sl_DBus, expected);
        @(negedge clk);
        busIdle();
        @(posedge clk);
        #1;
        checkOutput({tag, " ackdrop"}, {31'b0, bus.Sl_xferAck}, 32'd0);
    endtask

    task automatic opbWrite(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_DBus   = data;
        bus.OPB_BE     = be;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " ack"}, {31'b0, bus.Sl_xferAck}, 32'd1);
        checkOutput({tag, " dbus"}, bus.Sl_DBus, 32'd0);
        @(negedge clk);
        busIdle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        userData    = '0;
        userValid   = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        busIdle();
        rstN = 1'b0;

        #3;
        checkOutput("reset ack", {31'b0, bus.Sl_xferAck}, 32'd0);
        checkOutput("reset dbus", bus.Sl_DBus, 32'd0);
        checkOutput("reset tied", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        opbRead("data after reset", BASE + 32'h0, 32'h00000000);
        opbRead("stat after reset", BASE + 32'h4, 32'h00000000);

        applyStimulus(32'hDEADBEEF);
        opbRead("stat new set", BASE + 32'h4, 32'h80000000);
        opbRead("data capture", BASE + 32'h0, 32'hDEADBEEF);
        opbRead("stat new cleared", BASE + 32'h4, 32'h00000000);

        applyStimulus(32'h11111111);
        applyStimulus(32'h22222222);
        opbRead("stat overrun", BASE + 32'h4, 32'hC0000000);
        opbWrite("w1c overrun", BASE + 32'h4, 32'h40000000, 4'hF);
        opbRead("stat after w1c", BASE + 32'h4, 32'h80000000);
        opbRead("data latest", BASE + 32'h0, 32'h22222222);
        opbRead("stat clean", BASE + 32'h4, 32'h00000000);

        opbWrite("freeze be3 off", BASE + 32'h4, 32'h00000001, 4'hE);
        opbRead("stat freeze gated", BASE + 32'h4, 32'h00000000);
        opbWrite("freeze on", BASE + 32'h4, 32'h00000001, 4'hF);
        opbRead("stat frozen", BASE + 32'h4, 32'h00000001);
        applyStimulus(32'h12345678);
        opbRead("data frozen", BASE + 32'h0, 32'h22222222);
        opbRead("stat frozen no new", BASE + 32'h4, 32'h00000001);
        opbWrite("freeze off", BASE + 32'h4, 32'h00000000, 4'hF);
        applyStimulus(32'hCAFEF00D);
        opbRead("data unfrozen", BASE + 32'h0, 32'hCAFEF00D);
        opbRead("stat unfrozen", BASE + 32'h4, 32'h00000000);

        // Capture lands in the ACK cycle of a DATA read while select is held an extra cycle.
        applyStimulus(32'hAAAA5555);
        @(negedge clk);
        bus.OPB_ABus   = BASE;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("collide ack", {31'b0, bus.Sl_xferAck}, 32'd1);
        checkOutput("collide old data", bus.Sl_DBus, 32'hAAAA5555);
        @(negedge clk);
        userData  = 32'h5555AAAA;
        userValid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("held select no reack", {31'b0, bus.Sl_xferAck}, 32'd0);
        checkOutput("held select dbus", bus.Sl_DBus, 32'd0);
        @(negedge clk);
        userValid = 1'b0;
        busIdle();
        opbRead("stat collide", BASE + 32'h4, 32'hC0000000);
        opbRead("data collide", BASE + 32'h0, 32'h5555AAAA);
        opbWrite("w1c collide", BASE + 32'h4, 32'h40000000, 4'hF);
        opbRead("stat after collide", BASE + 32'h4, 32'h00000000);

        opbWrite("write data ignored", BASE + 32'h0, 32'hFFFFFFFF, 4'hF);
        opbRead("data unchanged", BASE + 32'h0, 32'h5555AAAA);
        opbRead("unmapped 0xC", BASE + 32'hC, 32'h00000000);
        opbRead("top of window", BASE + 32'hFC, 32'h00000000);

        @(negedge clk);
        bus.OPB_ABus   = BASE + 32'h100;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("out of window 1", {31'b0, bus.Sl_xferAck}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("out of window 2", {31'b0, bus.Sl_xferAck}, 32'd0);
        @(negedge clk);
        busIdle();

        // Reset asserted asynchronously in the middle of an ACK cycle.
        applyStimulus(32'h0BADF00D);
        @(negedge clk);
        bus.OPB_ABus   = BASE;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midread ack", {31'b0, bus.Sl_xferAck}, 32'd1);
        checkOutput("midread data", bus.Sl_DBus, 32'h0BADF00D);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midread reset ack", {31'b0, bus.Sl_xferAck}, 32'd0);
        checkOutput("midread reset dbus", bus.Sl_DBus, 32'd0);
        @(negedge clk);
        busIdle();
        @(negedge clk);
        rstN = 1'b1;
        opbRead("data after midread reset", BASE + 32'h0, 32'h00000000);
        opbRead("stat after midread reset", BASE + 32'h4, 32'h00000000);

`ifdef SNAP_TIMESTAMP_EN
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        userData  = 32'h00C0FFEE;
        userValid = 1'b1;
        @(negedge clk);
        userValid = 1'b0;
        opbRead("tstamp", BASE + 32'h8, 32'd10);
`else
        opbRead("tstamp absent", BASE + 32'h8, 32'h00000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
